fp_issue_ctrl: RTL
==================

# fp_issue_ctrl

Request-side controller for the floating-point add/sub unit (`addsub`). It accepts operand pairs on a valid/ready stream and launches each one on the unit with a single-cycle `add_start` pulse, holding the operands stable until the operation finishes. It then waits for `add_done`, or for a timeout, and presents the result on a valid/ready output stream. It sits between the instruction/operand front end and `addsub`, and drives the initiator side of the interface the unit exposes.

## Interface
- `TIMEOUT_CYCLES`, default 16: cycles after the `add_start` cycle before a missing `add_done` is declared a timeout; legal range 1..255.
- `clk` input 1: single clock; all state updates on the rising edge.
- `n_rst` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: operand pair valid.
- `in_ready` output 1: controller can accept a pair.
- `in_mode` input 1: 0 = add, 1 = subtract.
- `in_op1`, `in_op2` input 32 each: IEEE-754 single-precision operands.
- `add_start` output 1: one-cycle launch pulse to `addsub`.
- `mode` output 1: operation select to `addsub`; held stable from ISSUE through capture.
- `op1`, `op2` output 32 each: operands to `addsub`; held stable from ISSUE through capture.
- `add_result` input 32: result from `addsub`.
- `add_done` input 1: result valid from `addsub`.
- `add_overflow` input 1: overflow flag from `addsub`; qualified by `add_done`.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `out_result` output 32: captured result.
- `out_overflow` output 1: captured overflow flag.
- `out_timeout` output 1: result slot closed by timeout.
- `busy` output 1: high in any state other than IDLE.
- `op_count` output 16: completed output handshakes; wraps from 0xFFFF to 0.
- `ovf_count` output 8: results delivered with overflow; saturates at 0xFF.

## Operation
- States:
  - IDLE: `in_ready` = 1.
    - `in_valid` high → latch `in_mode`/`in_op1`/`in_op2` into `mode`/`op1`/`op2`, go to ISSUE.
  - ISSUE: `add_start` = 1 for exactly this cycle; timeout counter cleared.
    - `add_done` high in this cycle → capture, go to HOLD.
    - Otherwise go to WAIT.
  - WAIT: timeout counter increments each cycle.
    - `add_done` high → capture, go to HOLD.
    - Counter reaches `TIMEOUT_CYCLES` with no `add_done` → capture timeout, go to HOLD.
    - `add_done` wins if it arrives on the same cycle the timeout would fire.
  - HOLD: `out_valid` = 1; `out_result`, `out_overflow`, `out_timeout` stable.
    - `out_ready` high and `in_valid` high → latch the new pair, go to ISSUE (back-to-back).
    - `out_ready` high and `in_valid` low → go to IDLE.
    - `out_ready` low → stay in HOLD.
- Capture:
  - Normal completion: `out_result` = `add_result`, `out_overflow` = `add_overflow`, `out_timeout` = 0.
  - Timeout: `out_result` = 0, `out_overflow` = 0, `out_timeout` = 1.
- `in_ready` = IDLE | (HOLD & `out_ready`). It is combinational from state and `out_ready`.
- `add_done` is ignored in IDLE and HOLD; a stray pulse there changes nothing.
- `op_count` increments on every output handshake, timeouts included.
- `ovf_count` increments on an output handshake with `out_overflow` = 1.
- Operands are not inspected or modified; NaN, Inf and zero pass through unchanged.

## Timing
- Reset (asynchronous, immediate):
  - State → IDLE.
  - `add_start`, `out_valid`, `out_overflow`, `out_timeout`, `busy` = 0.
  - `mode` = 0; `op1`, `op2`, `out_result` = 0.
  - `op_count`, `ovf_count` = 0.
  - `in_ready` = 1 once `n_rst` is high.
- Reset mid-operation drops the in-flight operation with no output. `add_start` falls asynchronously.
- Latency, input handshake at cycle t:
  - `add_start` high in cycle t+1.
  - `add_done` in cycle t+1+k → `out_valid` from cycle t+2+k.
  - A zero-cycle unit (`add_done` in the ISSUE cycle) gives `out_valid` at t+2.
- Timeout: with no `add_done`, `out_valid` rises at t+2+`TIMEOUT_CYCLES`.
- Throughput: one operation per 2+k cycles with back-to-back HOLD→ISSUE.
- `add_start` is never high on two consecutive cycles.

## Structure
- Shared package `fp_pkg`:
  - `FP_WIDTH` = 32.
  - `MODE_ADD` = 1'b0, `MODE_SUB` = 1'b1.
  - `issue_state_t` enum {IDLE, ISSUE, WAIT, HOLD}.
- Natural sub-module: `fp_timeout_cnt`, an 8-bit counter with clear, enable and a terminal-count compare against `TIMEOUT_CYCLES`.
- All other logic (state register, operand/result registers, statistics counters) lives in `fp_issue_ctrl`.

## Test plan
- Basic add:
  - Stimulus: `in_op1` = 0x41480000 (12.5), `in_op2` = 0x418C0000 (17.5), mode 0; behavioural addsub stub with 1-cycle done.
  - Required: single `add_start` pulse; `out_result` = 0x41F00000; `out_valid` 3 cycles after the input handshake; `op_count` = 1.
- Backpressure and back-to-back:
  - Stimulus: hold `out_ready` low 5 cycles, keep `in_valid` high with a second pair.
  - Required: `out_result` stable through the stall; `in_ready` low until `out_ready` rises; second `add_start` the cycle after that handshake.
- Timeout:
  - Stimulus: stub never asserts `add_done`, `TIMEOUT_CYCLES` = 16.
  - Required: `out_valid` at t+18; `out_timeout` = 1; `out_result` = 0.
- Overflow:
  - Stimulus: stub returns `add_overflow` = 1.
  - Required: `out_overflow` = 1; `ovf_count` increments only on the output handshake.
- Reset in WAIT:
  - Stimulus: assert `n_rst` = 0 mid-wait.
  - Required: `add_start`/`busy`/`out_valid` = 0 immediately; no output after release; counters = 0.
- Counter wrap and race:
  - Stimulus: preload `op_count` to 0xFFFF and complete one operation; separately, `add_done` on the exact timeout cycle.
  - Required: `op_count` wraps to 0; `out_timeout` = 0 with the real result captured.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared floating-point definitions: word width, add/sub mode encoding and
// the issue-controller state type.
package fp_pkg;
  localparam int FP_WIDTH = 32;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } issue_state_t;
endpackage

// File: rtl/fp_timeout_cnt.sv
// 8-bit wait counter for the issue controller: cleared on launch, counts
// waiting cycles and flags the cycle on which the timeout fires.
module fp_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 8'd0;
    end else if (en) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count is zero in the first waiting cycle, so the Nth waiting cycle
  // (the one that reaches TIMEOUT_CYCLES) holds N-1.
  assign tc = en && (cnt_q == 8'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/fp_issue_ctrl.sv
// Request-side controller for the addsub unit: accepts operand pairs, pulses
// add_start, waits for add_done or a timeout and presents the result.
module fp_issue_ctrl
  import fp_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_mode,
  input  logic [FP_WIDTH-1:0] in_op1,
  input  logic [FP_WIDTH-1:0] in_op2,
  output logic                add_start,
  output logic                mode,
  output logic [FP_WIDTH-1:0] op1,
  output logic [FP_WIDTH-1:0] op2,
  input  logic [FP_WIDTH-1:0] add_result,
  input  logic                add_done,
  input  logic                add_overflow,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [FP_WIDTH-1:0] out_result,
  output logic                out_overflow,
  output logic                out_timeout,
  output logic                busy,
  output logic [15:0]         op_count,
  output logic [7:0]          ovf_count
);
  issue_state_t        state_q, state_d;
  logic                mode_q, mode_d;
  logic [FP_WIDTH-1:0] op1_q, op1_d;
  logic [FP_WIDTH-1:0] op2_q, op2_d;
  logic [FP_WIDTH-1:0] res_q, res_d;
  logic                ovf_q, ovf_d;
  logic                tmo_q, tmo_d;
  logic [15:0]         op_count_q, op_count_d;
  logic [7:0]          ovf_count_q, ovf_count_d;
  logic                tmo_clr, tmo_en, tmo_tc;
  logic                out_hs;

  fp_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk  (clk),
    .n_rst(n_rst),
    .clr  (tmo_clr),
    .en   (tmo_en),
    .tc   (tmo_tc)
  );

  assign out_hs = (state_q == HOLD) && out_ready;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    res_d       = res_q;
    ovf_d       = ovf_q;
    tmo_d       = tmo_q;
    tmo_clr     = 1'b0;
    tmo_en      = 1'b0;
    op_count_d  = op_count_q;
    ovf_count_d = ovf_count_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mode_d  = in_mode;
          op1_d   = in_op1;
          op2_d   = in_op2;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        tmo_clr = 1'b1;
        if (add_done) begin
          res_d   = add_result;
          ovf_d   = add_overflow;
          tmo_d   = 1'b0;
          state_d = HOLD;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        tmo_en = 1'b1;
        // A real completion takes priority over a timeout in the same cycle.
        if (add_done) begin
          res_d   = add_result;
          ovf_d   = add_overflow;
          tmo_d   = 1'b0;
          state_d = HOLD;
        end else if (tmo_tc) begin
          res_d   = '0;
          ovf_d   = 1'b0;
          tmo_d   = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (in_valid) begin
            mode_d  = in_mode;
            op1_d   = in_op1;
            op2_d   = in_op2;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (out_hs) begin
      op_count_d = op_count_q + 16'd1;
      if (ovf_q && (ovf_count_q != 8'hFF)) begin
        ovf_count_d = ovf_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      res_q       <= '0;
      ovf_q       <= 1'b0;
      tmo_q       <= 1'b0;
      op_count_q  <= 16'd0;
      ovf_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      res_q       <= res_d;
      ovf_q       <= ovf_d;
      tmo_q       <= tmo_d;
      op_count_q  <= op_count_d;
      ovf_count_q <= ovf_count_d;
    end
  end

  // Decoded from the state register so that reset drops add_start at once.
  assign add_start    = (state_q == ISSUE);
  assign busy         = (state_q != IDLE);
  assign out_valid    = (state_q == HOLD);
  assign in_ready     = (state_q == IDLE) || out_hs;
  assign mode         = mode_q;
  assign op1          = op1_q;
  assign op2          = op2_q;
  assign out_result   = res_q;
  assign out_overflow = ovf_q;
  assign out_timeout  = tmo_q;
  assign op_count     = op_count_q;
  assign ovf_count    = ovf_count_q;
endmodule
